// File: rtl/sha256_block_sequencer.sv
// SHA-256 block sequencer: takes the message as a byte stream, fills the
// 64-byte block buffer, appends the 0x80 / zero / bit-length padding, and runs
// the compression core for ROUNDS cycles per block.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   msg_valid/last    host byte valid / final-byte qualifier
//   msg_byte          host data byte
//   msg_ready         byte accepted when msg_valid & msg_ready
//   buf_we/addr/wdata block buffer write port
//   word_idx          W[0..15] selected from the buffer
//   w_sel_msg         1 = core takes W from buffer, 0 = expanded schedule
//   core_start        one-cycle pulse, load working vars from H
//   hash_init         with core_start: load H from IV (first block)
//   round_cnt         current round index
//   core_en           core performs one round this cycle
//   digest_valid      one-cycle pulse, final H is the digest
//   busy              high in every state except IDLE
//   overflow_err      sticky, message longer than the byte counter allows
//
// All outputs are registered and line up with the state register; block
// buffer writes therefore appear one cycle after the byte is accepted.
module sha256_block_sequencer #(
   parameter int unsigned LEN_W  = 64,
   parameter int unsigned ROUNDS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       msg_valid,
   input  logic       msg_last,
   input  logic [7:0] msg_byte,
   output logic       msg_ready,
   output logic       buf_we,
   output logic [5:0] buf_addr,
   output logic [7:0] buf_wdata,
   output logic [3:0] word_idx,
   output logic       w_sel_msg,
   output logic       core_start,
   output logic       hash_init,
   output logic [5:0] round_cnt,
   output logic       core_en,
   output logic       digest_valid,
   output logic       busy,
   output logic       overflow_err
);

   localparam int unsigned CNT_W = LEN_W - 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAD80, S_PADZ, S_LEN, S_START, S_ROUND, S_FIN
   } state_e;

   state_e           state_q, state_d;
   logic [5:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pend_q, pend_d;     // 0x80 still owed after a full last block
   logic             first_q, first_d;
   logic             extra_q, extra_d;   // padding spills into an extra block
   logic             lastblk_q, lastblk_d;
   logic             ovf_q, ovf_d;
   logic [5:0]       round_q, round_d;

   logic       msg_ready_q, buf_we_q, w_sel_msg_q, core_start_q, hash_init_q;
   logic       core_en_q, digest_valid_q, busy_q;
   logic [5:0] buf_addr_q;
   logic [7:0] buf_wdata_q;
   logic [3:0] word_idx_q;

   logic       we_d;
   logic [7:0] wdata_d;
   logic       accept;
   logic [63:0] len_bits;
   logic [5:0]  len_shift;
   logic [7:0]  len_byte;

   assign accept    = msg_valid & msg_ready_q;
   // Big-endian bit length: address 56 carries the most significant byte.
   assign len_bits  = 64'({count_q, 3'b000});
   assign len_shift = {3'd7 - ptr_q[2:0], 3'b000};
   assign len_byte  = 8'(len_bits >> len_shift);

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         count_q   <= '0;
         pend_q    <= 1'b0;
         first_q   <= 1'b1;
         extra_q   <= 1'b0;
         lastblk_q <= 1'b0;
         ovf_q     <= 1'b0;
         round_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         first_q   <= first_d;
         extra_q   <= extra_d;
         lastblk_q <= lastblk_d;
         ovf_q     <= ovf_d;
         round_q   <= round_d;
      end
   end

   // Next-state, counters and buffer write request
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      pend_d    = pend_q;
      first_d   = first_q;
      extra_d   = extra_q;
      lastblk_d = lastblk_q;
      ovf_d     = ovf_q;
      round_d   = round_q;
      we_d      = 1'b0;
      wdata_d   = 8'h00;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               if (count_q == CNT_MAX) begin
                  // Byte would wrap the length: drop it, pad with saturated count.
                  ovf_d = 1'b1;
                  if (msg_last) state_d = S_PAD80;
               end else begin
                  we_d    = 1'b1;
                  wdata_d = msg_byte;
                  ptr_d   = ptr_q + 6'd1;
                  count_d = count_q + CNT_W'(1);
                  if (ptr_q == 6'd63) begin
                     state_d = S_START;
                     if (msg_last) pend_d = 1'b1;
                  end else if (msg_last) begin
                     state_d = S_PAD80;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end
         S_PAD80: begin
            we_d    = 1'b1;
            wdata_d = 8'h80;
            ptr_d   = ptr_q + 6'd1;
            if (ptr_q <= 6'd54) begin
               state_d = S_PADZ;
            end else if (ptr_q == 6'd55) begin
               state_d = S_LEN;
            end else begin
               // No room for the length: close this block with zeros first.
               extra_d = 1'b1;
               state_d = (ptr_q == 6'd63) ? S_START : S_PADZ;
            end
         end
         S_PADZ: begin
            we_d  = 1'b1;
            ptr_d = ptr_q + 6'd1;
            if (extra_q && ptr_q == 6'd63)       state_d = S_START;
            else if (!extra_q && ptr_q == 6'd55) state_d = S_LEN;
         end
         S_LEN: begin
            we_d    = 1'b1;
            wdata_d = len_byte;
            ptr_d   = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
               lastblk_d = 1'b1;
               state_d   = S_START;
            end
         end
         S_START: begin
            first_d = 1'b0;
            round_d = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            round_d = round_q + 6'd1;
            if (round_q == LAST_ROUND) begin
               round_d = '0;
               ptr_d   = '0;
               if (lastblk_q) begin
                  state_d = S_FIN;
               end else if (pend_q) begin
                  pend_d  = 1'b0;
                  state_d = S_PAD80;
               end else if (extra_q) begin
                  extra_d = 1'b0;
                  state_d = S_PADZ;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_FIN: begin
            state_d   = S_IDLE;
            ptr_d     = '0;
            count_d   = '0;
            pend_d    = 1'b0;
            first_d   = 1'b1;
            extra_d   = 1'b0;
            lastblk_d = 1'b0;
            round_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs, decoded from the next state so they align with state_q
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msg_ready_q    <= 1'b0;
         buf_we_q       <= 1'b0;
         buf_addr_q     <= '0;
         buf_wdata_q    <= '0;
         word_idx_q     <= '0;
         w_sel_msg_q    <= 1'b0;
         core_start_q   <= 1'b0;
         hash_init_q    <= 1'b0;
         core_en_q      <= 1'b0;
         digest_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         msg_ready_q    <= (state_d == S_IDLE) || (state_d == S_LOAD);
         buf_we_q       <= we_d;
         buf_addr_q     <= we_d ? ptr_q : 6'd0;
         buf_wdata_q    <= wdata_d;
         word_idx_q     <= (state_d == S_ROUND) ? round_d[3:0] : 4'd0;
         w_sel_msg_q    <= (state_d == S_ROUND) && (round_d < 6'd16);
         core_start_q   <= (state_d == S_START);
         hash_init_q    <= (state_d == S_START) && first_q;
         core_en_q      <= (state_d == S_ROUND);
         digest_valid_q <= (state_d == S_FIN);
         busy_q         <= (state_d != S_IDLE);
      end
   end

   assign msg_ready    = msg_ready_q;
   assign buf_we       = buf_we_q;
   assign buf_addr     = buf_addr_q;
   assign buf_wdata    = buf_wdata_q;
   assign word_idx     = word_idx_q;
   assign w_sel_msg    = w_sel_msg_q;
   assign core_start   = core_start_q;
   assign hash_init    = hash_init_q;
   assign round_cnt    = round_q;
   assign core_en      = core_en_q;
   assign digest_valid = digest_valid_q;
   assign busy         = busy_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Testbench for sha256_block_sequencer: drives byte-stream messages and checks
// buffer writes, core sequencing and overflow against a SHA-256 padding model.
module tb_sha256_block_sequencer;

   typedef logic [7:0] bq_t[$];

   logic clk;
   logic rst;
   logic msg_valid, msg_last;
   logic [7:0] msg_byte;
   logic sel;   // 0 = observe default instance, 1 = observe LEN_W=12 instance

   logic [32:0] a_bus, b_bus;
   logic a_rdy, a_we, a_ws, a_cs, a_hi, a_ce, a_dv, a_busy, a_ovf;
   logic b_rdy, b_we, b_ws, b_cs, b_hi, b_ce, b_dv, b_busy, b_ovf;
   logic [5:0] a_addr, a_rc, b_addr, b_rc;
   logic [7:0] a_wd, b_wd;
   logic [3:0] a_wi, b_wi;

   logic       msg_ready, buf_we, w_sel_msg, core_start, hash_init, core_en;
   logic       digest_valid, busy, overflow_err;
   logic [5:0] buf_addr, round_cnt;
   logic [7:0] buf_wdata;
   logic [3:0] word_idx;

   int checks = 0;
   int errors = 0;

   sha256_block_sequencer dut_a (
      .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_last(msg_last),
      .msg_byte(msg_byte), .msg_ready(a_rdy), .buf_we(a_we), .buf_addr(a_addr),
      .buf_wdata(a_wd), .word_idx(a_wi), .w_sel_msg(a_ws), .core_start(a_cs),
      .hash_init(a_hi), .round_cnt(a_rc), .core_en(a_ce), .digest_valid(a_dv),
      .busy(a_busy), .overflow_err(a_ovf)
   );

   sha256_block_sequencer #(.LEN_W(12)) dut_b (
      .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_last(msg_last),
      .msg_byte(msg_byte), .msg_ready(b_rdy), .buf_we(b_we), .buf_addr(b_addr),
      .buf_wdata(b_wd), .word_idx(b_wi), .w_sel_msg(b_ws), .core_start(b_cs),
      .hash_init(b_hi), .round_cnt(b_rc), .core_en(b_ce), .digest_valid(b_dv),
      .busy(b_busy), .overflow_err(b_ovf)
   );

   assign a_bus = {a_rdy, a_we, a_addr, a_wd, a_wi, a_ws, a_cs, a_hi, a_rc, a_ce, a_dv, a_busy, a_ovf};
   assign b_bus = {b_rdy, b_we, b_addr, b_wd, b_wi, b_ws, b_cs, b_hi, b_rc, b_ce, b_dv, b_busy, b_ovf};
   assign {msg_ready, buf_we, buf_addr, buf_wdata, word_idx, w_sel_msg, core_start,
           hash_init, round_cnt, core_en, digest_valid, busy, overflow_err} = sel ? b_bus : a_bus;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: record observed events, sampled on the falling edge
   int cyc = 0;
   logic [13:0] wq[$];     // {addr, data}
   logic [10:0] rq[$];     // {round_cnt, w_sel_msg, word_idx}
   logic        sq[$];     // hash_init per core_start
   int          scyc[$];
   int          dq[$];
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         if (buf_we)       wq.push_back({buf_addr, buf_wdata});
         if (core_en)      rq.push_back({round_cnt, w_sel_msg, word_idx});
         if (core_start) begin
            sq.push_back(hash_init);
            scyc.push_back(cyc);
         end
         if (digest_valid) dq.push_back(cyc);
      end
   end

   // Reference: standard SHA-256 padding of the (length-limited) message
   task automatic model(input bq_t msg, input int limit, output bq_t exp, output int nb);
      int n;
      logic [63:0] l;
      exp = {};
      n = (msg.size() < limit) ? msg.size() : limit;
      for (int i = 0; i < n; i++) exp.push_back(msg[i]);
      exp.push_back(8'h80);
      while (exp.size() % 64 != 56) exp.push_back(8'h00);
      l = 64'(n) << 3;
      for (int k = 7; k >= 0; k--) exp.push_back(l[8*k +: 8]);
      nb = exp.size() / 64;
   endtask

   function automatic bq_t rand_msg(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Stimulus: stream a message, optionally with idle gaps, then wait for digest
   task automatic run_msg(input bq_t msg, input bit gaps, input bit wait_done,
                          output int rdy_busy, output int ovf_at);
      int tmo, d0;
      logic acc;
      rdy_busy = 0;
      ovf_at   = 0;
      d0       = dq.size();
      for (int i = 0; i < msg.size(); i++) begin
         if (gaps) begin
            msg_valid = 1'b0;
            msg_byte  = 8'($urandom);
            msg_last  = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         msg_valid = 1'b1;
         msg_byte  = msg[i];
         msg_last  = (i == msg.size() - 1);
         tmo = 0;
         do begin
            acc = msg_ready;
            @(posedge clk); #1;
            tmo++;
         end while (!acc && tmo < 1000);
         if (!acc) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: byte %0d not accepted after %0d cycles", i, tmo);
            msg_valid = 1'b0;
            return;
         end
         if (overflow_err === 1'b1 && ovf_at == 0) ovf_at = i + 1;
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      if (wait_done) begin
         tmo = 0;
         while (tmo < 3000) begin
            @(posedge clk); #1;
            tmo++;
            if (dq.size() > d0) break;
            if (msg_ready) rdy_busy++;
         end
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; msg_valid = 1'b0; msg_last = 1'b0; msg_byte = 8'h00; sel = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({msg_ready, buf_we, buf_addr, buf_wdata, word_idx, w_sel_msg, core_start, hash_init,
           round_cnt, core_en, digest_valid, busy, overflow_err} !== 33'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", a_bus);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({msg_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL idle_ready: got ready=%b busy=%b want ready=1 busy=0", msg_ready, busy);
      end
   endtask

   task automatic test_abc();
      bq_t msg, exp;
      int nb, w0, r0, s0, d0, rb, oa, lat;
      logic [13:0] gw;
      logic [10:0] gr, wr;
      msg = '{8'h61, 8'h62, 8'h63};
      model(msg, 1 << 30, exp, nb);
      w0 = wq.size(); r0 = rq.size(); s0 = sq.size(); d0 = dq.size();
      run_msg(msg, 1'b0, 1'b1, rb, oa);
      checks++;
      if (wq.size() - w0 !== exp.size()) begin
         errors++; $display("FAIL abc_write_count: got %0d want %0d", wq.size() - w0, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL abc_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      checks++;
      if (sq.size() - s0 !== 1 || sq[s0] !== 1'b1) begin
         errors++; $display("FAIL abc_core_start: got %0d starts want 1 with hash_init=1", sq.size() - s0);
      end
      checks++;
      if (rq.size() - r0 !== 64) begin
         errors++; $display("FAIL abc_round_count: got %0d want 64", rq.size() - r0);
      end
      for (int j = 0; j < 64; j++) begin
         wr = {6'(j), 1'(j < 16), 4'(j % 16)};
         gr = (r0 + j < rq.size()) ? rq[r0 + j] : 11'bx;
         checks++;
         if (gr !== wr) begin
            errors++; $display("FAIL abc_round[%0d]: got %h want %h", j, gr, wr);
         end
      end
      lat = (dq.size() > d0 && scyc.size() > 0) ? dq[d0] - scyc[scyc.size() - 1] : -1;
      checks++;
      if (dq.size() - d0 !== 1 || lat !== 65) begin
         errors++; $display("FAIL abc_digest: got %0d pulses at start+%0d want 1 at start+65", dq.size() - d0, lat);
      end
   endtask

   task automatic test_len55();
      bq_t msg, exp;
      int nb, w0, s0, d0, rb, oa;
      logic [13:0] gw;
      msg = rand_msg(55);
      model(msg, 1 << 30, exp, nb);
      w0 = wq.size(); s0 = sq.size(); d0 = dq.size();
      run_msg(msg, 1'b0, 1'b1, rb, oa);
      checks++;
      if (wq.size() - w0 !== 64) begin
         errors++; $display("FAIL len55_write_count: got %0d want 64", wq.size() - w0);
      end
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL len55_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      checks++;
      if (sq.size() - s0 !== 1 || dq.size() - d0 !== 1) begin
         errors++; $display("FAIL len55_blocks: got %0d starts %0d digests want 1 1", sq.size() - s0, dq.size() - d0);
      end
   endtask

   task automatic test_len56();
      bq_t msg, exp;
      int nb, w0, r0, s0, d0, rb, oa;
      logic [13:0] gw;
      logic [10:0] gr, wr;
      msg = rand_msg(56);
      model(msg, 1 << 30, exp, nb);
      w0 = wq.size(); r0 = rq.size(); s0 = sq.size(); d0 = dq.size();
      run_msg(msg, 1'b0, 1'b1, rb, oa);
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL len56_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      checks++;
      if (sq.size() - s0 !== 2) begin
         errors++; $display("FAIL len56_start_count: got %0d want 2", sq.size() - s0);
      end else begin
         checks++;
         if ({sq[s0], sq[s0 + 1]} !== 2'b10) begin
            errors++; $display("FAIL len56_hash_init: got %b%b want 10", sq[s0], sq[s0 + 1]);
         end
      end
      for (int j = 0; j < 128; j++) begin
         wr = {6'(j % 64), 1'((j % 64) < 16), 4'(j % 16)};
         gr = (r0 + j < rq.size()) ? rq[r0 + j] : 11'bx;
         checks++;
         if (gr !== wr) begin
            errors++; $display("FAIL len56_round[%0d]: got %h want %h", j, gr, wr);
         end
      end
      checks++;
      if (dq.size() - d0 !== 1) begin
         errors++; $display("FAIL len56_digest: got %0d want 1", dq.size() - d0);
      end
   endtask

   task automatic test_len64();
      bq_t msg, exp;
      int nb, w0, s0, rb, oa;
      logic [13:0] gw;
      msg = rand_msg(64);
      model(msg, 1 << 30, exp, nb);
      w0 = wq.size(); s0 = sq.size();
      run_msg(msg, 1'b0, 1'b1, rb, oa);
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL len64_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      checks++;
      if (sq.size() - s0 !== 2) begin
         errors++; $display("FAIL len64_start_count: got %0d want 2", sq.size() - s0);
      end
      checks++;
      if (rb !== 0) begin
         errors++; $display("FAIL len64_ready_while_busy: got %0d cycles want 0", rb);
      end
   endtask

   task automatic test_back_to_back();
      bq_t msg, exp;
      int nb, w0, r0, s0, rb, oa, nsel;
      logic [13:0] gw;
      logic [10:0] gr, wr;
      msg = rand_msg(130);
      model(msg, 1 << 30, exp, nb);
      w0 = wq.size(); r0 = rq.size(); s0 = sq.size();
      run_msg(msg, 1'b1, 1'b1, rb, oa);
      checks++;
      if (wq.size() - w0 !== exp.size()) begin
         errors++; $display("FAIL b2b_write_count: got %0d want %0d", wq.size() - w0, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL b2b_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      checks++;
      if (sq.size() - s0 !== 3) begin
         errors++; $display("FAIL b2b_start_count: got %0d want 3", sq.size() - s0);
      end
      nsel = 0;
      for (int j = 0; j < 192; j++) begin
         wr = {6'(j % 64), 1'((j % 64) < 16), 4'(j % 16)};
         gr = (r0 + j < rq.size()) ? rq[r0 + j] : 11'bx;
         if (gr[4] === 1'b1) nsel++;
         checks++;
         if (gr !== wr) begin
            errors++; $display("FAIL b2b_round[%0d]: got %h want %h", j, gr, wr);
         end
      end
      checks++;
      if (nsel !== 48) begin
         errors++; $display("FAIL b2b_w_sel_count: got %0d want 48", nsel);
      end
   endtask

   task automatic test_reset_mid();
      bq_t msg;
      int rb, oa, s1, d1;
      bit found;
      msg = rand_msg(64);
      run_msg(msg, 1'b0, 1'b0, rb, oa);
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
         @(posedge clk); #1;
         if (core_en === 1'b1 && round_cnt === 6'd30) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rstmid_reach_round30: got not reached want reached");
      end
      rst = 1'b0;
      #1;
      checks++;
      if (a_bus !== 33'h0 || b_bus !== 33'h0) begin
         errors++; $display("FAIL rstmid_outputs: got %h %h want 0", a_bus, b_bus);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      s1 = sq.size(); d1 = dq.size();
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (sq.size() !== s1 || dq.size() !== d1 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_no_pulses: got %0d starts %0d digests busy=%b want 0 0 0",
                            sq.size() - s1, dq.size() - d1, busy);
      end
      test_abc();
   endtask

   task automatic test_overflow();
      bq_t msg, exp;
      int nb, w0, d0, rb, oa;
      logic [13:0] gw;
      sel = 1'b1;
      msg = rand_msg(512);
      model(msg, 511, exp, nb);
      w0 = wq.size(); d0 = dq.size();
      run_msg(msg, 1'b0, 1'b1, rb, oa);
      checks++;
      if (oa !== 512) begin
         errors++; $display("FAIL ovf_first_byte: got %0d want 512", oa);
      end
      checks++;
      if (overflow_err !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err);
      end
      checks++;
      if (wq.size() - w0 !== exp.size()) begin
         errors++; $display("FAIL ovf_write_count: got %0d want %0d", wq.size() - w0, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         gw = (w0 + i < wq.size()) ? wq[w0 + i] : 14'bx;
         checks++;
         if (gw !== {6'(i % 64), exp[i]}) begin
            errors++; $display("FAIL ovf_write[%0d]: got %h want %h", i, gw, {6'(i % 64), exp[i]});
         end
      end
      gw = (wq.size() >= 2) ? wq[wq.size() - 2] : 14'bx;
      checks++;
      if ({gw[7:0], wq[wq.size() - 1]} !== {8'h0F, 6'd63, 8'hF8}) begin
         errors++; $display("FAIL ovf_length_field: got %h %h want 0f f8", gw[7:0], wq[wq.size() - 1]);
      end
      checks++;
      if (dq.size() - d0 !== 1) begin
         errors++; $display("FAIL ovf_digest: got %0d want 1", dq.size() - d0);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_len55();
      test_len56();
      test_len64();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
